// File: rtl/regfile_pkg.sv
// Shared constants and types for the CPU register file storage stage.
package regfile_pkg;
  localparam int REG_WIDTH    = 32;
  localparam int REG_COUNT    = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int ZERO_REG_IDX = 31;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef logic [REG_WIDTH-1:0]  reg_word_t;
endpackage

// File: rtl/reg_en_dff.sv
// WIDTH-bit enable flop with active-low asynchronous clear; one per architectural register.
module reg_en_dff #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/regfile_write_bank.sv
// Register file storage and write port: one-hot write decode, per-register enable flops, ack and write counter.
// Optional macro REGFILE_ZERO_REG_EN hardwires register NUM_REGS-1 to zero and drops writes to it.
module regfile_write_bank
  import regfile_pkg::*;
#(
  parameter int WIDTH    = REG_WIDTH,
  parameter int NUM_REGS = REG_COUNT,
  parameter int ADDR_W   = REG_ADDR_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      RegWrite,
  input  logic [ADDR_W-1:0]         WriteRegister,
  input  logic [WIDTH-1:0]          WriteData,
  output logic [NUM_REGS*WIDTH-1:0] regs,
  output logic                      wr_ack,
  output logic [15:0]               wr_count
);

  logic [NUM_REGS-1:0] dec;
  logic                accepted;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
`ifdef REGFILE_ZERO_REG_EN
    if (k == NUM_REGS-1) begin : g_zero
      // Zero register: no storage, and its decode bit stays low so writes are not acknowledged.
      assign dec[k] = 1'b0;
      assign regs[k*WIDTH +: WIDTH] = '0;
    end else begin : g_store
      assign dec[k] = RegWrite && (WriteRegister == ADDR_W'(k));
      reg_en_dff #(.WIDTH(WIDTH)) u_dff (
        .clk   (clk),
        .rst_n (reset),
        .en    (dec[k]),
        .d     (WriteData),
        .q     (regs[k*WIDTH +: WIDTH])
      );
    end
`else
    assign dec[k] = RegWrite && (WriteRegister == ADDR_W'(k));
    reg_en_dff #(.WIDTH(WIDTH)) u_dff (
      .clk   (clk),
      .rst_n (reset),
      .en    (dec[k]),
      .d     (WriteData),
      .q     (regs[k*WIDTH +: WIDTH])
    );
`endif
  end

  assign accepted = |dec;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ack   <= 1'b0;
      wr_count <= '0;
    end else begin
      wr_ack <= accepted;
      if (accepted) wr_count <= wr_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_regfile_write_bank.sv
// Directed self-checking bench for regfile_write_bank (default or REGFILE_ZERO_REG_EN build).
module tb_regfile_write_bank;
  import regfile_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              RegWrite;
  logic [4:0]        WriteRegister;
  logic [31:0]       WriteData;
  logic [1023:0]     regs;
  logic              wr_ack;
  logic [15:0]       wr_count;

  reg_word_t exp_regs [32];
  int checks = 0;
  int errors = 0;

  regfile_write_bank dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .regs          (regs),
    .wr_ack        (wr_ack),
    .wr_count      (wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag);
    for (int k = 0; k < 32; k++)
      chk($sformatf("%s_r%0d", tag, k), {32'h0, regs[k*32 +: 32]}, {32'h0, exp_regs[k]});
  endtask

  task automatic clear_model();
    for (int k = 0; k < 32; k++) exp_regs[k] = '0;
  endtask

  // Present a write at the falling edge, let one rising edge capture it, sample 1 ns later.
  task automatic do_write(input logic we, input logic [4:0] idx, input logic [31:0] data);
    @(negedge clk);
    RegWrite      = we;
    WriteRegister = idx;
    WriteData     = data;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    RegWrite      = 1'b0;
    WriteRegister = 'x;
    WriteData     = 'x;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    RegWrite = 1'b0;
    WriteRegister = '0;
    WriteData = '0;
    clear_model();
    #1;
    chk_all("rst0");
    chk("rst0_ack", {63'h0, wr_ack}, 64'h0);
    chk("rst0_cnt", {48'h0, wr_count}, 64'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Basic write
    do_write(1'b1, 5'd5, 32'hDEADBEEF);
    exp_regs[5] = 32'hDEADBEEF;
    chk_all("basic");
    chk("basic_ack", {63'h0, wr_ack}, 64'h1);
    chk("basic_cnt", {48'h0, wr_count}, 64'h1);
    idle();
    chk("basic_ack_drop", {63'h0, wr_ack}, 64'h0);

    // RegWrite low: no effect
    do_write(1'b0, 5'd3, 32'h12345678);
    chk_all("nowe");
    chk("nowe_ack", {63'h0, wr_ack}, 64'h0);
    chk("nowe_cnt", {48'h0, wr_count}, 64'h1);

    // Back-to-back writes to R7
    do_write(1'b1, 5'd7, 32'h1);
    chk("b2b_ack1", {63'h0, wr_ack}, 64'h1);
    chk("b2b_r7a", {32'h0, regs[7*32 +: 32]}, 64'h1);
    do_write(1'b1, 5'd7, 32'h2);
    exp_regs[7] = 32'h2;
    chk("b2b_ack2", {63'h0, wr_ack}, 64'h1);
    chk("b2b_cnt", {48'h0, wr_count}, 64'h3);
    chk_all("b2b");
    idle();
    chk("b2b_ack_drop", {63'h0, wr_ack}, 64'h0);

    // Asynchronous reset mid-cycle with nonzero contents
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    clear_model();
    chk_all("arst");
    chk("arst_ack", {63'h0, wr_ack}, 64'h0);
    chk("arst_cnt", {48'h0, wr_count}, 64'h0);
    // Write presented while reset still low is ignored
    do_write(1'b1, 5'd9, 32'hCAFEF00D);
    chk("arst_wr_r9", {32'h0, regs[9*32 +: 32]}, 64'h0);
    chk("arst_wr_cnt", {48'h0, wr_count}, 64'h0);
    @(negedge clk);
    RegWrite = 1'b0;
    reset = 1'b1;

    // Full sweep R0..R30
    for (int k = 0; k < 31; k++) begin
      do_write(1'b1, 5'(k), 32'(k) * 32'h01010101);
      exp_regs[k] = 32'(k) * 32'h01010101;
    end
    chk("sweep_cnt31", {48'h0, wr_count}, 64'd31);
    do_write(1'b1, 5'd31, 32'hFFFFFFFF);
`ifdef REGFILE_ZERO_REG_EN
    chk("sweep_r31_ack", {63'h0, wr_ack}, 64'h0);
    chk("sweep_r31_cnt", {48'h0, wr_count}, 64'd31);
`else
    exp_regs[31] = 32'hFFFFFFFF;
    chk("sweep_r31_ack", {63'h0, wr_ack}, 64'h1);
    chk("sweep_r31_cnt", {48'h0, wr_count}, 64'd32);
`endif
    idle();
    chk_all("sweep");

    // Counter wrap
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("wrap_rst_cnt", {48'h0, wr_count}, 64'h0);
    reset = 1'b1;
    RegWrite = 1'b1;
    WriteRegister = 5'd1;
    WriteData = 32'hA5A5A5A5;
    repeat (65535) @(posedge clk);
    #1;
    chk("wrap_ffff", {48'h0, wr_count}, 64'hFFFF);
    @(posedge clk);
    #1;
    chk("wrap_zero", {48'h0, wr_count}, 64'h0);
    chk("wrap_ack", {63'h0, wr_ack}, 64'h1);
    chk("wrap_r1", {32'h0, regs[1*32 +: 32]}, 64'hA5A5A5A5);
    @(negedge clk);
    RegWrite = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_bank.md
# regfile_write_bank

Storage and write-port stage of the CPU register file: 32 general-purpose 32-bit registers, a 5-to-32 one-hot write decoder, and per-register enable flops. Its registered outputs feed the read-port multiplexers directly downstream, one 32-way bit-slice mux per read port. All architectural register state lives here. The read muxes are purely combinational on these outputs.

## Interface
Parameters:
- `WIDTH`, 32, data width of each register.
- `NUM_REGS`, 32, register count; must equal 2**`ADDR_W`.
- `ADDR_W`, 5, write-address width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately when low.
- `RegWrite`  in  1  write enable for the current cycle.
- `WriteRegister`  in  `ADDR_W`  destination register index.
- `WriteData`  in  `WIDTH`  data to write.
- `regs`  out  `NUM_REGS*WIDTH`  flattened register contents; register k occupies bits [k*WIDTH +: WIDTH]. Connects straight to the read muxes.
- `wr_ack`  out  1  registered; high for one cycle after each accepted write.
- `wr_count`  out  16  registered count of accepted writes; wraps 0xFFFF→0x0000.

## Operation
- Decoder: `dec[k] = RegWrite && (WriteRegister == k)`. At most one bit is high.
- Each register k is an enable flop: on a rising edge with `dec[k]`=1, it loads `WriteData`; otherwise it holds.
- An accepted write is a cycle with `RegWrite`=1 that targets a writable register. `wr_ack` goes high for that next cycle and `wr_count` increments by 1.
- Writes to a non-writable register (see Configuration) are dropped. They produce no `wr_ack` and no count increment.
- Back-to-back writes to the same index: the last one wins and each is counted.
- Reset asserted mid-operation: all registers, `wr_ack` and `wr_count` clear to 0 asynchronously. A write presented on the same edge that reset releases is ignored if `reset` is still low at that edge.
- X on `WriteRegister` while `RegWrite`=0 has no effect.

## Timing
- Write latency is 1 cycle. Data presented at edge N appears on `regs` after edge N.
- There is no same-cycle write-to-read bypass. A reader sampling during cycle N sees the old value, and the datapath handles the hazard.
- Reset values: every `regs` bit is 0, `wr_ack`=0, `wr_count`=0.
- There is no handshake or backpressure. A write is always accepted in the cycle it is presented.

## Configuration
- Macro: `REGFILE_ZERO_REG_EN`.
- Defined: register `NUM_REGS-1` (X31/XZR) is hardwired to 0. It is built with no flops, its `regs` slice is constant 0, and writes to it are dropped as described above.
- Undefined: register `NUM_REGS-1` is an ordinary writable register, and all 32 indices count as accepted writes.

## Structure
- Shared package `regfile_pkg`:
  - Constants `REG_WIDTH`=32, `REG_COUNT`=32, `REG_ADDR_W`=5, `ZERO_REG_IDX`=31.
  - Typedef `reg_idx_t` (5-bit).
  - Typedef `reg_word_t` (32-bit).
- Sub-module `reg_en_dff`:
  - A `WIDTH`-bit D flip-flop with enable and active-low async reset.
  - Instantiated `NUM_REGS` times (or `NUM_REGS-1` with the macro defined) in a generate loop.
- The decoder, ack and counter logic stay in the top module.

## Test plan
- Reset: drive `reset`=0 mid-run after registers hold nonzero data → all 1024 `regs` bits, `wr_ack` and `wr_count` read 0 immediately, before any clock edge.
- Basic write: write 0xDEADBEEF to R5 → R5 slice = 0xDEADBEEF after the edge, all other slices unchanged, `wr_ack`=1 for exactly one cycle, `wr_count`=1.
- Full sweep: write k*0x01010101 to each R0–R30, then read back every slice → each matches. With `REGFILE_ZERO_REG_EN` defined, writing 0xFFFFFFFF to R31 leaves it 0 with `wr_count`=31 and no ack. Undefined, R31 reads 0xFFFFFFFF and `wr_count`=32.
- RegWrite low: `RegWrite`=0 with `WriteRegister`=3 and `WriteData`=0x12345678 → R3 unchanged, no ack, count unchanged.
- Back-to-back: write R7=0x1 then R7=0x2 on consecutive edges → R7=0x2, `wr_ack` high for 2 consecutive cycles, count +2.
- Counter wrap: preload via 65535 writes, then perform one more write → `wr_count`=0x0000.
